uart_tx_fifo: RTL and testbench

Buffered 8N1 UART transmitter that sits directly downstream of the ULPI parser in the ICEstick USB sniffer. It accepts parsed bytes on a simple write strobe, queues them in a small synchronous FIFO, and serialises them LSB-first onto the board's `tx` line at a fixed baud rate. This decouples the bursty parser output from the slow serial link. It also reports FIFO occupancy, overflow and a per-bit baud tick for debug LEDs.

---
 rtl/uart_tx_fifo.sv | 177 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a small synchronous FIFO feeding an LSB-first
// serialiser with a fixed baud divider. All outputs are registered.
module uart_tx_fifo #(
    parameter int BAUD_DIV = 104,
    parameter int FIFO_AW  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         din,
    input  logic               wr,
    output logic               full,
    output logic               empty,
    output logic [FIFO_AW:0]   count,
    output logic               overflow,
    output logic               tx,
    output logic               busy,
    output logic               bauds
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0]      CNT_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
    localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]   OCC_ONE  = (FIFO_AW + 1)'(1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2:0]           bit_q, bit_d;
    logic [7:0]           shift_q, shift_d;
    logic [7:0]           mem_q [DEPTH];
    logic [FIFO_AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [FIFO_AW:0]     count_q, count_d;
    logic                 full_q, full_d, empty_q, empty_d;
    logic                 overflow_q, overflow_d;
    logic                 tx_q, tx_d, busy_q, busy_d, bauds_q, bauds_d;
    logic                 pop, wr_acc, tick;

    assign tick = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty_q) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rptr_q];
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DATA: begin
                if (tick) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STOP: begin
                if (tick) begin
                    cnt_d = '0;
                    // Chain straight into the next frame so the link never idles.
                    if (!empty_q) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rptr_q];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed from next-state values so the registered copies line up.
    always_comb begin
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
        busy_d  = (state_d != IDLE);
        bauds_d = busy_d && (cnt_d == CNT_LAST);
    end

    always_comb begin
        wr_acc     = wr && !full_q;
        overflow_d = overflow_q || (wr && full_q);
        wptr_d     = wr_acc ? wptr_q + PTR_ONE : wptr_q;
        rptr_d     = pop ? rptr_q + PTR_ONE : rptr_q;
        case ({wr_acc, pop})
            2'b10:   count_d = count_q + OCC_ONE;
            2'b01:   count_d = count_q - OCC_ONE;
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CNT_FULL);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wptr_q] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            bauds_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            bauds_q    <= bauds_d;
        end
    end

    assign full     = full_q;
    assign empty    = empty_q;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign tx       = tx_q;
    assign busy     = busy_q;
    assign bauds    = bauds_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a frame-level timing model predicts every output each
// cycle, and a line decoder checks received bytes against a queue of accepted writes.
module tb_uart_tx_fifo;

    localparam int B     = 4;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int FRAME = 10 * B;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr  = 1'b0;
    logic [7:0]    din = 8'h00;
    logic          full, empty, overflow, tx, busy, bauds;
    logic [AW:0]   count;

    uart_tx_fifo #(.BAUD_DIV(B), .FIFO_AW(AW)) dut (
        .clk(clk), .rst(rst), .din(din), .wr(wr),
        .full(full), .empty(empty), .count(count), .overflow(overflow),
        .tx(tx), .busy(busy), .bauds(bauds)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] m_fifo[$];
    logic [7:0] exp_q[$];
    bit         m_active = 1'b0;
    bit         m_ovf = 1'b0;
    int         m_start = 0;
    int         cyc = 0;
    int         epoch = 0;
    logic [7:0] m_byte = 8'h00;
    bit         e_tx = 1'b1, e_busy = 1'b0, e_bauds = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, expv);
        end
    endfunction

    // Frame position j cycles after the pop edge: bit slot j/B, pulse on the last cycle of a slot.
    function automatic void model_outputs();
        int j, idx;
        e_busy  = m_active;
        e_tx    = 1'b1;
        e_bauds = 1'b0;
        if (m_active) begin
            j       = cyc - m_start;
            idx     = j / B;
            e_bauds = ((j % B) == B - 1);
            if (idx == 0)      e_tx = 1'b0;
            else if (idx <= 8) e_tx = m_byte[idx-1];
        end
    endfunction

    function automatic void model_step(input bit w, input logic [7:0] d);
        int  pre;
        bit  do_pop;
        cyc++;
        pre    = m_fifo.size();
        do_pop = 1'b0;
        if (!m_active) begin
            do_pop = (pre > 0);
        end else if (cyc == m_start + FRAME) begin
            if (pre > 0) do_pop = 1'b1;
            else         m_active = 1'b0;
        end
        if (do_pop) begin
            m_byte   = m_fifo.pop_front();
            m_active = 1'b1;
            m_start  = cyc;
        end
        if (w) begin
            if (pre == DEPTH) begin
                m_ovf = 1'b1;
            end else begin
                m_fifo.push_back(d);
                exp_q.push_back(d);
            end
        end
        model_outputs();
    endfunction

    function automatic void model_reset();
        m_fifo.delete();
        exp_q.delete();
        m_active = 1'b0;
        m_ovf    = 1'b0;
        epoch++;
        model_outputs();
    endfunction

    task automatic check_outputs();
        chk("tx", tx, e_tx);
        chk("busy", busy, e_busy);
        chk("bauds", bauds, e_bauds);
        chk("count", count, m_fifo.size());
        chk("full", full, m_fifo.size() == DEPTH);
        chk("empty", empty, m_fifo.size() == 0);
        chk("overflow", overflow, m_ovf);
    endtask

    task automatic cycle(input bit w, input logic [7:0] d);
        wr  = w;
        din = d;
        model_step(w, d);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drain();
        int guard = 0;
        while ((m_active || m_fifo.size() > 0) && guard < 3000) begin
            cycle(1'b0, 8'h00);
            guard++;
        end
        chk("drain_in_time", guard < 3000, 1);
        repeat (4) cycle(1'b0, 8'h00);
    endtask

    // Line decoder: samples mid-bit after each falling edge of tx.
    logic       mon_prev = 1'b1;
    logic [7:0] mon_b;
    logic       mon_stop;
    int         mon_ep;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && mon_prev && !tx) begin
                mon_ep = epoch;
                repeat (2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (B) @(negedge clk);
                    mon_b[i] = tx;
                end
                repeat (B) @(negedge clk);
                mon_stop = tx;
                mon_prev = tx;
                if (mon_ep == epoch) begin
                    chk("stop_bit", mon_stop, 1);
                    chk("frame_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) chk("rx_byte", mon_b, exp_q.pop_front());
                end
            end else begin
                mon_prev = tx;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int guard;
        repeat (2) @(negedge clk);
        model_reset();
        check_outputs();
        rst = 1'b0;

        // single byte from idle
        cycle(1'b1, 8'h55);
        drain();

        // fill past capacity: 17 accepted, 18th dropped
        for (int i = 0; i < 18; i++) cycle(1'b1, 8'(i));
        drain();

        // two back-to-back frames
        cycle(1'b1, 8'hA3);
        cycle(1'b1, 8'h0F);
        drain();

        // write landing on the end-of-stop pop edge with one byte queued
        cycle(1'b1, 8'h11);
        cycle(1'b1, 8'h22);
        guard = 0;
        while (!(m_active && (cyc + 1 - m_start) == FRAME) && guard < 200) begin
            cycle(1'b0, 8'h00);
            guard++;
        end
        chk("reach_stop_end", guard < 200, 1);
        cycle(1'b1, 8'h33);
        drain();

        // reset during data bit 3 with five bytes queued
        for (int i = 0; i < 6; i++) cycle(1'b1, 8'hC0 + 8'(i));
        guard = 0;
        while (!(m_active && (cyc - m_start) == 17) && guard < 200) begin
            cycle(1'b0, 8'h00);
            guard++;
        end
        chk("reach_bit3", guard < 200, 1);
        chk("queued_before_rst", count, 5);
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        cycle(1'b0, 8'h00);
        cycle(1'b0, 8'h00);
        rst = 1'b0;
        repeat (60) cycle(1'b0, 8'h00);

        // pointer wrap: 40 bytes in bursts of 16, 16, 8
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < ((k == 2) ? 8 : 16); i++) cycle(1'b1, 8'($urandom));
            drain();
        end
        chk("overflow_after_wrap", overflow, 0);

        // random traffic
        for (int i = 0; i < 500; i++) cycle($urandom_range(0, 11) == 0, 8'($urandom));
        drain();
        chk("all_bytes_received", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
